// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the DFT frame controller
package fft_pkg;

    localparam int NMAX = 4096;
    localparam int LW   = 13;
    localparam int PW   = LW + 3;
    localparam int A2W  = 4;
    localparam int A3W  = 3;
    localparam int A5W  = 2;

    localparam logic [A5W-1:0] STG5_OFF  = 2'd0;
    localparam logic [A5W-1:0] STG5_ONE  = 2'd1;
    localparam logic [A5W-1:0] STG5_PAIR = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ARMED,
        RUN,
        DRAIN
    } fft_state_e;

endpackage

// File: rtl/fft_len_calc.sv
// rtl/fft_len_calc.sv - iterative 2^a2 * 3^a3 * 5^a5 multiplier with sticky overflow
module fft_len_calc
    import fft_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           start,
    input  logic [A2W-1:0] a2,
    input  logic [A3W-1:0] a3,
    input  logic [A5W-1:0] a5,
    output logic           busy,
    output logic           valid,
    output logic [LW-1:0]  len,
    output logic           ovf
);

    logic           running;
    logic [PW-1:0]  prod_q, prod_d;
    logic           ovf_q, ovf_d;
    logic [A3W-1:0] rem3_q, rem3_d;
    logic [A5W-1:0] rem5_q, rem5_d;

    // valid/len/ovf describe the value being produced this cycle, so the
    // caller can latch the final product on the same edge as the last step
    always_comb begin
        prod_d = prod_q;
        ovf_d  = ovf_q;
        rem3_d = rem3_q;
        rem5_d = rem5_q;
        if (start) begin
            prod_d = PW'(1) << a2;
            ovf_d  = (a2 > A2W'($clog2(NMAX)));
            rem3_d = a3;
            rem5_d = a5;
        end else if (running) begin
            if (rem3_q != '0) begin
                prod_d = prod_q + (prod_q << 1);
                rem3_d = rem3_q - A3W'(1);
            end else if (rem5_q != '0) begin
                prod_d = prod_q + (prod_q << 2);
                rem5_d = rem5_q - A5W'(1);
            end
        end
        if (prod_d > PW'(NMAX)) begin
            ovf_d = 1'b1;
        end
    end

    assign valid = (start || running) && (rem3_d == '0) && (rem5_d == '0);
    assign busy  = running;
    assign len   = prod_d[LW-1:0];
    assign ovf   = ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            rem3_q  <= '0;
            rem5_q  <= '0;
        end else if (clr) begin
            running <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            rem3_q  <= '0;
            rem5_q  <= '0;
        end else begin
            running <= (start || running) && !valid;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
            rem3_q  <= rem3_d;
            rem5_q  <= rem5_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame controller: sizes the DFT, gates N input samples, counts N outputs
module fft_frame_ctrl
    import fft_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [A2W-1:0] cfg_a2,
    input  logic [A3W-1:0] cfg_a3,
    input  logic [A5W-1:0] cfg_a5,
    input  logic           flush,
    input  logic           in_en,
    output logic           dp_en,
    output logic           sof,
    output logic           eof,
    input  logic           out_en,
    output logic [A2W-1:0] stg2,
    output logic [A3W-1:0] stg3,
    output logic [A5W-1:0] stg5,
    output logic [LW-1:0]  frame_len,
    output logic           busy,
    output logic           err,
    output logic           ovf,
    output logic           done
);

    fft_state_e     state_q, state_d;
    logic [A2W-1:0] a2_q;
    logic [A3W-1:0] a3_q;
    logic [A5W-1:0] a5_q;
    logic [LW-1:0]  in_cnt, out_cnt, last_idx;
    logic           active, out_inc;
    logic           load_cfg, load_stg, err_d, ovf_d, done_d;
    logic           calc_start, calc_busy, calc_valid, calc_ovf;
    logic [LW-1:0]  calc_len;

    fft_len_calc u_len_calc (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .start (calc_start),
        .a2    (a2_q),
        .a3    (a3_q),
        .a5    (a5_q),
        .busy  (calc_busy),
        .valid (calc_valid),
        .len   (calc_len),
        .ovf   (calc_ovf)
    );

    assign last_idx  = frame_len - LW'(1);
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cfg   = 1'b0;
        load_stg   = 1'b0;
        calc_start = 1'b0;
        err_d      = 1'b0;
        active     = (state_q == ARMED) || (state_q == RUN) || (state_q == DRAIN);
        dp_en      = in_en && ((state_q == ARMED) || (state_q == RUN)) && (in_cnt < frame_len);
        sof        = dp_en && (in_cnt == '0);
        eof        = dp_en && (in_cnt == last_idx);
        ovf_d      = in_en && active && !dp_en;
        out_inc    = out_en && active && (out_cnt < frame_len);
        done_d     = out_inc && (out_cnt == last_idx);

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    load_cfg = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                calc_start = !calc_busy;
                if (calc_valid) begin
                    if (calc_ovf || (a5_q > STG5_PAIR)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        load_stg = 1'b1;
                        state_d  = ARMED;
                    end
                end
            end
            ARMED: begin
                if (dp_en) begin
                    state_d = (in_cnt == last_idx) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (dp_en && (in_cnt == last_idx)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_d) begin
            state_d = IDLE;
        end
        // abort overrides everything, including a same-cycle config request
        if (flush) begin
            state_d  = IDLE;
            load_cfg = 1'b0;
            load_stg = 1'b0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a2_q      <= '0;
            a3_q      <= '0;
            a5_q      <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            stg2      <= '0;
            stg3      <= '0;
            stg5      <= STG5_OFF;
            frame_len <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            err  <= err_d;
            ovf  <= ovf_d;
            done <= done_d;
            if (load_cfg) begin
                a2_q <= cfg_a2;
                a3_q <= cfg_a3;
                a5_q <= cfg_a5;
            end
            if (flush) begin
                in_cnt    <= '0;
                out_cnt   <= '0;
                stg2      <= '0;
                stg3      <= '0;
                stg5      <= STG5_OFF;
                frame_len <= '0;
            end else if (load_stg) begin
                in_cnt    <= '0;
                out_cnt   <= '0;
                stg2      <= a2_q;
                stg3      <= a3_q;
                stg5      <= a5_q;
                frame_len <= calc_len;
            end else if (done_d) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (dp_en) begin
                    in_cnt <= in_cnt + LW'(1);
                end
                if (out_inc) begin
                    out_cnt <= out_cnt + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    logic           clk = 1'b0;
    logic           rst, cfg_valid, flush, in_en, out_en;
    logic [3:0]     cfg_a2;
    logic [2:0]     cfg_a3;
    logic [1:0]     cfg_a5;
    logic           cfg_ready, dp_en, sof, eof, busy, err, ovf, done;
    logic [3:0]     stg2;
    logic [2:0]     stg3;
    logic [1:0]     stg5;
    logic [LW-1:0]  frame_len;

    int tests = 0;
    int fails = 0;
    int n_dp = 0, n_ovf = 0, n_done = 0, n_err = 0, n_sof = 0, n_eof = 0;
    int sof_at = -1, eof_at = -1;
    longint prev_len = 0;
    int prev_a2 = 0, prev_a3 = 0, prev_a5 = 0;

    fft_frame_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_a2(cfg_a2), .cfg_a3(cfg_a3), .cfg_a5(cfg_a5), .flush(flush),
        .in_en(in_en), .dp_en(dp_en), .sof(sof), .eof(eof), .out_en(out_en),
        .stg2(stg2), .stg3(stg3), .stg5(stg5), .frame_len(frame_len),
        .busy(busy), .err(err), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dp_en === 1'b1) begin
            n_dp++;
            if (sof === 1'b1) sof_at = n_dp;
            if (eof === 1'b1) eof_at = n_dp;
        end
        if (sof === 1'b1) n_sof++;
        if (eof === 1'b1) n_eof++;
        if (ovf === 1'b1) n_ovf++;
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_err++;
    end

    function automatic longint model_len(input int a2, input int a3, input int a5);
        longint n = 1;
        for (int i = 0; i < a2; i++) n = n * 2;
        for (int i = 0; i < a3; i++) n = n * 3;
        for (int i = 0; i < a5; i++) n = n * 5;
        return n;
    endfunction

    function automatic bit model_legal(input int a2, input int a3, input int a5);
        return (a5 <= 2) && (model_len(a2, a3, a5) <= NMAX);
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr_mon;
        n_dp = 0; n_ovf = 0; n_done = 0; n_err = 0; n_sof = 0; n_eof = 0;
        sof_at = -1; eof_at = -1;
    endtask

    task automatic send_cfg(input int a2, input int a3, input int a5);
        cfg_a2 = 4'(a2); cfg_a3 = 3'(a3); cfg_a5 = 2'(a5);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // holds in_en high and counts cycles until the first admitted sample or err
    task automatic measure_calc(output int k);
        in_en = 1'b1;
        k = 0;
        #1;
        while (dp_en !== 1'b1 && err !== 1'b1 && k < 64) begin
            @(posedge clk);
            #3;
            k++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_valid = 1'b0; flush = 1'b0; in_en = 1'b0; out_en = 1'b0;
        cfg_a2 = '0; cfg_a3 = '0; cfg_a5 = '0;
        repeat (3) @(posedge clk);
        #2;
        tests++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_ready_busy: got %b%b expected 10", cfg_ready, busy); end
        tests++; if ({stg2, stg3, stg5} !== 9'd0 || frame_len !== '0) begin fails++; $display("FAIL reset_stages: got %0d/%0d/%0d len %0d expected 0", stg2, stg3, stg5, frame_len); end
        tests++; if ({err, ovf, done, dp_en} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b expected 0000", {err, ovf, done, dp_en}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int k;
        clr_mon();
        send_cfg(2, 1, 1);
        measure_calc(k);
        tests++; if (k != 3) begin fails++; $display("FAIL basic_calc_cycles: got %0d expected 3", k); end
        tests++; if (frame_len !== 13'd60) begin fails++; $display("FAIL basic_len: got %0d expected 60", frame_len); end
        tests++; if ({stg2, stg3, stg5} !== {4'd2, 3'd1, 2'd1}) begin fails++; $display("FAIL basic_stages: got %0d/%0d/%0d expected 2/1/1", stg2, stg3, stg5); end
        tests++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got ready %b busy %b expected 0 1", cfg_ready, busy); end
        repeat (60) tick();
        in_en = 1'b0;
        tick();
        tests++; if (n_dp != 60) begin fails++; $display("FAIL basic_dp_count: got %0d expected 60", n_dp); end
        tests++; if (sof_at != 1 || n_sof != 1) begin fails++; $display("FAIL basic_sof: got at %0d count %0d expected 1 1", sof_at, n_sof); end
        tests++; if (eof_at != 60 || n_eof != 1) begin fails++; $display("FAIL basic_eof: got at %0d count %0d expected 60 1", eof_at, n_eof); end
        tests++; if (n_ovf != 0) begin fails++; $display("FAIL basic_no_ovf: got %0d expected 0", n_ovf); end
        out_en = 1'b1;
        repeat (60) tick();
        out_en = 1'b0;
        tests++; if (done !== 1'b1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL basic_done: got done %b ready %b expected 1 1", done, cfg_ready); end
        tick();
        tests++; if (done !== 1'b0 || n_done != 1) begin fails++; $display("FAIL basic_done_once: got done %b count %0d expected 0 1", done, n_done); end
        tests++; if (frame_len !== 13'd60 || stg5 !== 2'd1) begin fails++; $display("FAIL basic_hold_idle: got %0d/%0d expected 60/1", frame_len, stg5); end
    endtask

    task automatic test_ovf_pulses;
        send_cfg(3, 4, 1);
        repeat (6) tick();
        tests++; if (frame_len !== 13'd3240) begin fails++; $display("FAIL ovf_len: got %0d expected 3240", frame_len); end
        tests++; if ({stg2, stg3, stg5} !== {4'd3, 3'd4, 2'd1}) begin fails++; $display("FAIL ovf_stages: got %0d/%0d/%0d expected 3/4/1", stg2, stg3, stg5); end
        clr_mon();
        in_en = 1'b1;
        repeat (3245) tick();
        in_en = 1'b0;
        tick();
        tests++; if (n_dp != 3240) begin fails++; $display("FAIL ovf_dp_count: got %0d expected 3240", n_dp); end
        tests++; if (n_ovf != 5) begin fails++; $display("FAIL ovf_pulses: got %0d expected 5", n_ovf); end
        out_en = 1'b1;
        repeat (3240) tick();
        out_en = 1'b0;
        tick();
        tests++; if (n_done != 1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL ovf_done: got %0d ready %b expected 1 1", n_done, cfg_ready); end
    endtask

    task automatic test_err;
        send_cfg(1, 0, 3);
        repeat (3) tick();
        tests++; if (err !== 1'b0 || cfg_ready !== 1'b0) begin fails++; $display("FAIL err_a5_early: got err %b ready %b expected 0 0", err, cfg_ready); end
        tick();
        tests++; if (err !== 1'b1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL err_a5_pulse: got err %b ready %b expected 1 1", err, cfg_ready); end
        tests++; if (stg5 !== 2'd1 || frame_len !== 13'd3240) begin fails++; $display("FAIL err_a5_hold: got %0d/%0d expected 1/3240", stg5, frame_len); end
        tick();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_width: got %b expected 0", err); end
        send_cfg(12, 1, 0);
        repeat (2) tick();
        tests++; if (err !== 1'b1 || cfg_ready !== 1'b1) begin fails++; $display("FAIL err_len_pulse: got err %b ready %b expected 1 1", err, cfg_ready); end
        tests++; if (frame_len !== 13'd3240 || stg2 !== 4'd3) begin fails++; $display("FAIL err_len_hold: got %0d/%0d expected 3240/3", frame_len, stg2); end
        tick();
    endtask

    task automatic test_overlap;
        send_cfg(2, 1, 1);
        repeat (3) tick();
        clr_mon();
        for (int c = 0; c < 75; c++) begin
            in_en  = (c < 60);
            out_en = (c >= 10);
            tick();
        end
        in_en = 1'b0; out_en = 1'b0;
        tick();
        tests++; if (n_dp != 60 || n_eof != 1) begin fails++; $display("FAIL overlap_in: got %0d eof %0d expected 60 1", n_dp, n_eof); end
        tests++; if (n_done != 1 || n_ovf != 0) begin fails++; $display("FAIL overlap_done: got done %0d ovf %0d expected 1 0", n_done, n_ovf); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL overlap_idle: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_flush;
        send_cfg(2, 1, 1);
        repeat (3) tick();
        clr_mon();
        in_en = 1'b1;
        repeat (17) tick();
        in_en = 1'b0;
        flush = 1'b1;
        cfg_valid = 1'b1;
        tick();
        flush = 1'b0;
        cfg_valid = 1'b0;
        tests++; if (n_dp != 17) begin fails++; $display("FAIL flush_dp: got %0d expected 17", n_dp); end
        tests++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL flush_idle: got ready %b busy %b expected 1 0", cfg_ready, busy); end
        tests++; if ({stg2, stg3, stg5} !== 9'd0 || frame_len !== '0) begin fails++; $display("FAIL flush_clear: got %0d/%0d/%0d len %0d expected 0", stg2, stg3, stg5, frame_len); end
        out_en = 1'b1;
        repeat (5) tick();
        out_en = 1'b0;
        tick();
        tests++; if (n_done != 0) begin fails++; $display("FAIL flush_no_done: got %0d expected 0", n_done); end
        clr_mon();
        send_cfg(1, 0, 0);
        tick();
        tests++; if (frame_len !== 13'd2 || stg2 !== 4'd1) begin fails++; $display("FAIL flush_next_cfg: got %0d/%0d expected 2/1", frame_len, stg2); end
        in_en = 1'b1;
        tick();
        out_en = 1'b1;
        tick();
        in_en = 1'b0;
        tick();
        out_en = 1'b0;
        tests++; if (done !== 1'b1 || n_dp != 2) begin fails++; $display("FAIL flush_next_run: got done %b dp %0d expected 1 2", done, n_dp); end
        tick();
        prev_len = 2; prev_a2 = 1; prev_a3 = 0; prev_a5 = 0;
    endtask

    task automatic test_random;
        int a2, a3, a5, k, in_sent, out_sent, g;
        longint n;
        for (int it = 0; it < 8; it++) begin
            a2 = $urandom_range(0, 5);
            a3 = $urandom_range(0, 2);
            a5 = $urandom_range(0, 3);
            n  = model_len(a2, a3, a5);
            clr_mon();
            send_cfg(a2, a3, a5);
            measure_calc(k);
            tests++; if (k != 1 + a3 + a5) begin fails++; $display("FAIL rand_calc_cycles: cfg %0d/%0d/%0d got %0d expected %0d", a2, a3, a5, k, 1 + a3 + a5); end
            if (!model_legal(a2, a3, a5)) begin
                in_en = 1'b0;
                tests++; if (err !== 1'b1 || frame_len !== LW'(prev_len) || stg5 !== 2'(prev_a5)) begin fails++; $display("FAIL rand_err: cfg %0d/%0d/%0d got err %b len %0d stg5 %0d expected 1 %0d %0d", a2, a3, a5, err, frame_len, stg5, prev_len, prev_a5); end
                tick();
            end else begin
                tests++; if (frame_len !== LW'(n) || {stg2, stg3, stg5} !== {4'(a2), 3'(a3), 2'(a5)}) begin fails++; $display("FAIL rand_cfg: got len %0d stg %0d/%0d/%0d expected %0d %0d/%0d/%0d", frame_len, stg2, stg3, stg5, n, a2, a3, a5); end
                in_sent = 1; out_sent = 0; g = 0;
                out_en = ($urandom_range(0, 1) == 1);
                if (out_en) out_sent = 1;
                while (out_sent < n && g < 20000) begin
                    tick();
                    g++;
                    in_en = (in_sent < n) && ($urandom_range(0, 3) != 0);
                    if (in_en) in_sent++;
                    out_en = (out_sent < in_sent) && ($urandom_range(0, 2) != 0);
                    if (out_en) out_sent++;
                end
                tick();
                in_en = 1'b0; out_en = 1'b0;
                tick();
                tests++; if (n_dp != n || n_sof != 1 || n_eof != 1) begin fails++; $display("FAIL rand_in: got dp %0d sof %0d eof %0d expected %0d 1 1", n_dp, n_sof, n_eof, n); end
                tests++; if (n_done != 1 || n_ovf != 0 || cfg_ready !== 1'b1) begin fails++; $display("FAIL rand_done: got done %0d ovf %0d ready %b expected 1 0 1", n_done, n_ovf, cfg_ready); end
                prev_len = n; prev_a2 = a2; prev_a3 = a3; prev_a5 = a5;
            end
        end
    endtask

    task automatic test_async_reset;
        send_cfg(2, 1, 1);
        repeat (3) tick();
        in_en = 1'b1;
        repeat (20) tick();
        #2;
        rst = 1'b1;
        cfg_valid = 1'b1; cfg_a2 = 4'd1; cfg_a3 = 3'd0; cfg_a5 = 2'd0;
        #1;
        tests++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || dp_en !== 1'b0) begin fails++; $display("FAIL arst_state: got busy %b ready %b dp %b expected 0 1 0", busy, cfg_ready, dp_en); end
        tests++; if ({stg2, stg3, stg5} !== 9'd0 || frame_len !== '0) begin fails++; $display("FAIL arst_stages: got %0d/%0d/%0d len %0d expected 0", stg2, stg3, stg5, frame_len); end
        in_en = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL arst_cfg_accept: got busy %b expected 1", busy); end
        tick();
        tests++; if (frame_len !== 13'd2 || stg2 !== 4'd1) begin fails++; $display("FAIL arst_cfg_len: got %0d/%0d expected 2/1", frame_len, stg2); end
        clr_mon();
        in_en = 1'b1; out_en = 1'b1;
        repeat (2) tick();
        in_en = 1'b0; out_en = 1'b0;
        tick();
        tests++; if (n_dp != 2 || n_done != 1) begin fails++; $display("FAIL arst_frame: got dp %0d done %0d expected 2 1", n_dp, n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf_pulses();
        test_err();
        test_overlap();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame-level controller for the mixed-radix PUSCH DFT datapath. It accepts a DFT size as radix exponents (N = 2^a2 · 3^a3 · 5^a5), computes and range-checks N, and drives the static stage-select inputs of the radix-2/3/5 reorder/butterfly chains. It admits exactly N input samples, counts N output samples, and then releases the datapath for the next configuration. It sits between the PUSCH transform-precoding control and the FFT datapath.

## Interface
- NMAX, 4096: largest legal DFT size.
- LW, 13: width of length and counter fields (must hold NMAX).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration; high only in IDLE.
- cfg_a2  in  4  radix-2 exponent.
- cfg_a3  in  3  radix-3 exponent.
- cfg_a5  in  2  radix-5 exponent; legal range 0..2.
- flush  in  1  synchronous abort.
- in_en  in  1  upstream sample strobe.
- dp_en  out  1  gated sample strobe to the datapath.
- sof / eof  out  1  combinational flags: first / Nth admitted sample.
- out_en  in  1  datapath output strobe.
- stg2  out  4  radix-2 stage count.
- stg3  out  3  radix-3 stage count.
- stg5  out  2  radix-5 stage select (0 = off, 1 = single stage, 2 = reorder25 pair).
- frame_len  out  LW  N of the active frame.
- busy  out  1  state is not IDLE.
- err  out  1  one-cycle pulse: illegal configuration.
- ovf  out  1  one-cycle pulse: in_en was dropped because N samples were already admitted.
- done  out  1  one-cycle pulse: N outputs counted.

## Operation
- FSM states: IDLE, CALC, ARMED, RUN, DRAIN.
- IDLE: cfg_ready=1. When cfg_valid is high, latch the exponents and go to CALC.
- CALC: iterative product.
  - First cycle: prod = 1<<a2. Set the overflow flag if a2 > 12.
  - Then one ×3 step per cycle, a3 times (prod + (prod<<1)).
  - Then one ×5 step per cycle, a5 times (prod + (prod<<2)).
  - Keep an internal width of LW+3 bits. Set a sticky overflow flag if any intermediate value exceeds NMAX.
  - After the last step: if overflow or a5 > 2, pulse err and return to IDLE, leaving stage outputs and frame_len unchanged.
  - Otherwise load stg2=a2, stg3=a3, stg5=a5, frame_len=prod, and go to ARMED.
- ARMED: waits for the first in_en.
- RUN / DRAIN counters:
  - dp_en = in_en while in ARMED or RUN and in_cnt < N.
  - in_cnt increments on each dp_en.
  - The ARMED→RUN transition happens on the first dp_en.
  - RUN→DRAIN on the dp_en that makes in_cnt = N.
  - out_cnt increments on out_en in ARMED, RUN or DRAIN. It saturates at N; further out_en is ignored.
- In DRAIN, or any time in_cnt = N, in_en gives dp_en=0 and pulses ovf.
- When out_cnt reaches N, pulse done next cycle and return to IDLE.
  - stg*/frame_len hold their values into IDLE until the next successful CALC.
- flush in any state: next cycle state=IDLE, counters cleared, stg*/frame_len=0. flush wins over cfg_valid in the same cycle.
- A cfg_valid outside IDLE is ignored and does not queue.

## Timing
- Reset values: state IDLE, all counters 0, stg2=stg3=stg5=0, frame_len=0, err=ovf=done=0, busy=0, cfg_ready=1.
- Config accepted at edge T. CALC occupies cycles T+1 .. T+1+a3+a5. ARMED (or err) is visible at T+2+a3+a5.
- Stage outputs change only on the CALC exit edge or on flush/reset. They are stable whenever dp_en can be high.
- dp_en, sof, eof: combinational, same cycle as in_en.
- err, ovf, done: registered, one cycle wide.
- in_en and out_en may be coincident, including on the final sample. Both are counted.
- A frame with N=1 (a2=a3=a5=0): sof and eof are asserted together; the FSM goes directly ARMED→DRAIN.

## Structure
- Shared package fft_pkg holds: the state enum, NMAX, LW, the exponent widths, and the stg5 encodings (STG5_OFF/ONE/PAIR), which are also used by order5.
- One sub-module: fft_len_calc, the iterative exponent-to-length multiplier with overflow flag. It has a start/busy/valid handshake and is driven from CALC.

## Test plan
- a2=2, a3=1, a5=1 → CALC lasts 3 cycles, frame_len=60, stg5=1. Drive 60 in_en → sof on sample 1, eof on 60. Drive 60 out_en → done one cycle later; cfg_ready returns high.
- a2=3, a3=4, a5=1 → frame_len=3240, stg2=3, stg3=4. Drive 3245 in_en → exactly 3240 dp_en and 5 ovf pulses.
- a5=3 → err pulse after CALC, state IDLE, stg5 keeps its prior value. a2=12, a3=1 (12288) → err, frame_len unchanged.
- Continuous in_en/out_en overlap with out_en beginning 10 cycles after the first dp_en: both counters reach N, done fires once, and extra out_en after N is ignored.
- flush asserted at in_cnt=17 of N=60 → IDLE the next cycle, stg*=0, frame_len=0, no done. A following config runs normally.
- rst asserted mid-RUN (asynchronous, off-edge) → all outputs go to reset values immediately. cfg_valid held high through reset is accepted on the first edge after rst is released.
